decoder_scan: RTL and testbench

- Parametrised, registered successor to the team's 2-to-4 active-low decoder: SEL_W select bits drive 2^SEL_W one-cold outputs.
- Adds two modes: direct (host-loaded select) and auto-scan (self-cycling select with fixed dwell).
- Inserts a blanking gap between every output change, so it can drive multiplexed digit/LED commons without ghosting.
- Sits between control logic and the display/LED common lines.

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/decoder_scan_if.sv | 25 ++
 rtl/decoder_scan_cycle_timer.sv | 31 +++
 rtl/decoder_scan.sv | 174 +++++++++++++++++
 tb/tb_decoder_scan.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared decoder types and helpers: FSM state encoding, counter sizing and a
// width-generic select-to-one-hot/one-cold decode reused by other decoders.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } stateType;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  // Bits needed to hold 0..maxValue; never less than one bit.
  function automatic int counterWidth(input int maxValue);
    return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
  endfunction

  // Callers narrow the result with a size cast to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot_decode(
    input logic [MAX_SEL_W-1:0] sel,
    input logic                 active_low
  );
    logic [MAX_OUT_W-1:0] hot;
    hot      = '0;
    hot[sel] = 1'b1;
    return active_low ? ~hot : hot;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control/output bundle between the host logic and the scanning decoder.
interface decoder_scan_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             sel_load;
  logic [OUT_W-1:0] dec_out;
  logic [SEL_W-1:0] cur_sel;
  logic             frame_tick;

  modport master (
    output en, mode, sel_in, sel_load,
    input  dec_out, cur_sel, frame_tick
  );

  modport slave (
    input  en, mode, sel_in, sel_load,
    output dec_out, cur_sel, frame_tick
  );

endinterface

// File: rtl/decoder_scan_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         run,
  input  logic [W-1:0] loadValue,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over clear; counting stops at zero so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder with direct and auto-scan modes and a blanking
// gap between output changes, for ghost-free multiplexed display commons.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL_CYC  = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input logic           clk,
  input logic           rst_n,
  decoder_scan_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int DW_W  = counterWidth(DWELL_CYC);
  localparam int BL_W  = counterWidth(BLANK_CYC);

  localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'((DWELL_CYC > 0) ? DWELL_CYC - 1 : 0);
  localparam logic [BL_W-1:0]  BLANK_LOAD = BL_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [OUT_W-1:0] IDLE_PAT   = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  stateType         state, stateNext;
  logic [SEL_W-1:0] curSel, curSelNext;
  logic [SEL_W-1:0] directSel, directSelNext;
  logic [SEL_W-1:0] target, targetNext;
  logic [SEL_W-1:0] driveSel, blankTarget;
  logic [SEL_W-1:0] modeTarget, loadTarget;
  logic             curMode, curModeNext;
  logic             wrapPending, wrapNext;
  logic             frameTick, frameTickNext;
  logic             blankReq, enterBlank, enterDrive;
  logic             modeChange, dwellDone, blankDone;
  logic [OUT_W-1:0] decReg, decNext;

  assign directSelNext = bus.sel_load ? bus.sel_in : directSel;
  assign modeTarget    = bus.mode ? '0 : directSelNext;
  assign loadTarget    = (!curMode && bus.sel_load) ? bus.sel_in : target;
  assign modeChange    = (bus.mode != curMode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Every output change is routed through blankReq, which collapses straight
  // into DRIVE when no gap is configured.
  always_comb begin
    stateNext   = state;
    targetNext  = target;
    curModeNext = curMode;
    wrapNext    = wrapPending;
    blankReq    = 1'b0;
    blankTarget = target;
    enterDrive  = 1'b0;
    driveSel    = curSel;
    if (!bus.en) begin
      stateNext = IDLE;
      wrapNext  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          curModeNext = bus.mode;
          wrapNext    = 1'b0;
          blankReq    = 1'b1;
          blankTarget = modeTarget;
        end
        BLANK: begin
          if (modeChange) begin
            curModeNext = bus.mode;
            wrapNext    = 1'b0;
            blankReq    = 1'b1;
            blankTarget = modeTarget;
          end else begin
            targetNext = loadTarget;
            if (blankDone) begin
              stateNext  = DRIVE;
              enterDrive = 1'b1;
              driveSel   = loadTarget;
            end
          end
        end
        DRIVE: begin
          if (modeChange) begin
            curModeNext = bus.mode;
            wrapNext    = 1'b0;
            blankReq    = 1'b1;
            blankTarget = modeTarget;
          end else if (!curMode) begin
            if (bus.sel_load && (bus.sel_in != curSel)) begin
              blankReq    = 1'b1;
              blankTarget = bus.sel_in;
            end
          end else if (dwellDone) begin
            blankReq    = 1'b1;
            blankTarget = curSel + 1'b1;
            wrapNext    = &curSel;
          end
        end
        default: stateNext = IDLE;
      endcase
      if (blankReq) begin
        if (BLANK_CYC == 0) begin
          stateNext  = DRIVE;
          enterDrive = 1'b1;
          driveSel   = blankTarget;
        end else begin
          stateNext  = BLANK;
          targetNext = blankTarget;
        end
      end
    end
  end

  // Outputs are computed from the next state so they land on the same edge.
  always_comb begin
    curSelNext    = enterDrive ? driveSel : curSel;
    frameTickNext = enterDrive && wrapNext;
    enterBlank    = blankReq && (BLANK_CYC != 0);
    decNext       = IDLE_PAT;
    if (stateNext == DRIVE) begin
      decNext = OUT_W'(onehot_decode(MAX_SEL_W'(curSelNext), ACTIVE_LOW != 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curSel      <= '0;
      directSel   <= '0;
      target      <= '0;
      curMode     <= 1'b0;
      wrapPending <= 1'b0;
      frameTick   <= 1'b0;
      decReg      <= IDLE_PAT;
    end else begin
      curSel      <= curSelNext;
      directSel   <= directSelNext;
      target      <= targetNext;
      curMode     <= curModeNext;
      wrapPending <= wrapNext && !enterDrive;
      frameTick   <= frameTickNext;
      decReg      <= decNext;
    end
  end

  cycle_timer #(.W(DW_W)) dwellTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (enterDrive),
    .clear     (stateNext != DRIVE),
    .run       (state == DRIVE),
    .loadValue (DWELL_LOAD),
    .done      (dwellDone)
  );

  cycle_timer #(.W(BL_W)) blankTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (enterBlank),
    .clear     (stateNext != BLANK),
    .run       (state == BLANK),
    .loadValue (BLANK_LOAD),
    .done      (blankDone)
  );

  assign bus.dec_out    = decReg;
  assign bus.cur_sel    = curSel;
  assign bus.frame_tick = frameTick;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: a timeline model checked every cycle on two
// instances (one-cycle blank and no blank), plus directed literal checks.
module tb_decoder_scan;

  localparam int OUT_N = 4;
  localparam int DWELL = 4;

  typedef struct {
    int shown;
    int curIdx;
    int ds;
    int target;
    int darkLeft;
    int idle;
    int dwellLeft;
    int lastMode;
    int wrap;
    int tick;
  } modelT;

  logic  clk;
  logic  rst_n;
  logic  compareOn;
  int    checkCount;
  int    passCount;
  modelT mA, mB;

  logic [3:0] scanSeq [22] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
    4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
    4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b0111,
    4'b1111, 4'b1110
  };

  decoder_scan_if #(.SEL_W(2)) busA ();
  decoder_scan_if #(.SEL_W(2)) busB ();

  decoder_scan #(.SEL_W(2), .DWELL_CYC(DWELL), .BLANK_CYC(1), .ACTIVE_LOW(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  decoder_scan #(.SEL_W(2), .DWELL_CYC(DWELL), .BLANK_CYC(0), .ACTIVE_LOW(1)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int which, input logic en, input logic mode,
                               input logic [1:0] selIn, input logic selLoad);
    if (which == 0) begin
      busA.en = en; busA.mode = mode; busA.sel_in = selIn; busA.sel_load = selLoad;
    end else begin
      busB.en = en; busB.mode = mode; busB.sel_in = selIn; busB.sel_load = selLoad;
    end
  endtask

  function automatic modelT modelReset();
    modelT m;
    m.shown = -1; m.curIdx = 0; m.ds = 0; m.target = 0; m.darkLeft = 0;
    m.idle = 1; m.dwellLeft = 0; m.lastMode = 0; m.wrap = 0; m.tick = 0;
    return m;
  endfunction

  function automatic modelT showIdx(modelT m, int t);
    m.shown     = t;
    m.curIdx    = t;
    m.dwellLeft = DWELL;
    m.tick      = m.wrap;
    m.wrap      = 0;
    return m;
  endfunction

  function automatic modelT startGap(modelT m, int t, int blank);
    if (blank == 0) return showIdx(m, t);
    m.shown    = -1;
    m.target   = t;
    m.darkLeft = blank;
    return m;
  endfunction

  // One clock edge of the display timeline: dark gaps, dwell and host loads.
  function automatic modelT modelStep(modelT m, int blank, logic en, logic mode, int selIn, logic selLoad);
    int dsNew;
    dsNew  = selLoad ? selIn : m.ds;
    m.tick = 0;
    if (!en) begin
      m.idle  = 1;
      m.shown = -1;
      m.wrap  = 0;
    end else if (m.idle == 1 || int'(mode) != m.lastMode) begin
      m.idle     = 0;
      m.lastMode = int'(mode);
      m.wrap     = 0;
      m = startGap(m, mode ? 0 : dsNew, blank);
    end else if (m.shown < 0) begin
      if (!mode && selLoad) m.target = selIn;
      m.darkLeft--;
      if (m.darkLeft == 0) m = showIdx(m, m.target);
    end else if (!mode) begin
      if (selLoad && selIn != m.curIdx) m = startGap(m, selIn, blank);
    end else begin
      m.dwellLeft--;
      if (m.dwellLeft == 0) begin
        if (m.curIdx == OUT_N - 1) m.wrap = 1;
        m = startGap(m, (m.curIdx + 1) % OUT_N, blank);
      end
    end
    m.ds = dsNew;
    return m;
  endfunction

  function automatic logic [3:0] expDec(modelT m);
    logic [3:0] v;
    if (m.shown < 0) v = 4'b1111;
    else v = ~(4'b0001 << m.shown);
    return v;
  endfunction

  initial begin
    mA = modelReset();
    mB = modelReset();
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA = modelReset();
      mB = modelReset();
    end else begin
      mA = modelStep(mA, 1, busA.en, busA.mode, int'(busA.sel_in), busA.sel_load);
      mB = modelStep(mB, 0, busB.en, busB.mode, int'(busB.sel_in), busB.sel_load);
    end
  end

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("modelDecA", 32'(busA.dec_out), 32'(expDec(mA)));
      checkOutput("modelCurSelA", 32'(busA.cur_sel), mA.curIdx);
      checkOutput("modelTickA", 32'(busA.frame_tick), mA.tick);
      checkOutput("oneColdA", 32'($countones(~busA.dec_out) <= 1), 1);
      checkOutput("modelDecB", 32'(busB.dec_out), 32'(expDec(mB)));
      checkOutput("modelCurSelB", 32'(busB.cur_sel), mB.curIdx);
      checkOutput("modelTickB", 32'(busB.frame_tick), mB.tick);
      checkOutput("oneColdB", 32'($countones(~busB.dec_out) <= 1), 1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    checkCount = 0;
    passCount  = 0;
    compareOn  = 1'b0;
    rst_n      = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0);
    #1 compareOn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetDec", 32'(busA.dec_out), 32'hF);
    checkOutput("resetCurSel", 32'(busA.cur_sel), 0);
    checkOutput("resetTick", 32'(busA.frame_tick), 0);

    $display("[TB] enable in direct mode");
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1 checkOutput("enableBlank", 32'(busA.dec_out), 32'hF);
    @(posedge clk); #1 checkOutput("enableDrive0", 32'(busA.dec_out), 32'hE);

    $display("[TB] direct load and same-value reload");
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b1);
    @(posedge clk); #1 checkOutput("loadBlank", 32'(busA.dec_out), 32'hF);
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clk); #1 checkOutput("loadDrive2", 32'(busA.dec_out), 32'hB);
    checkOutput("loadCurSel", 32'(busA.cur_sel), 2);
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b1);
    @(posedge clk); #1 checkOutput("reloadNoBlank", 32'(busA.dec_out), 32'hB);
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clk); #1 checkOutput("reloadHold", 32'(busA.dec_out), 32'hB);

    $display("[TB] asynchronous reset while driving");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncResetDec", 32'(busA.dec_out), 32'hF);
    checkOutput("asyncResetCurSel", 32'(busA.cur_sel), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 checkOutput("rearmBlank", 32'(busA.dec_out), 32'hF);
    @(posedge clk); #1 checkOutput("rearmDrive0", 32'(busA.dec_out), 32'hE);

    $display("[TB] loads during blank");
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd3, 1'b1);
    @(posedge clk); #1 checkOutput("blankLoad3", 32'(busA.dec_out), 32'hF);
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd1, 1'b1);
    @(posedge clk); #1 checkOutput("latestLoadWins", 32'(busA.dec_out), 32'hD);
    checkOutput("latestLoadCurSel", 32'(busA.cur_sel), 1);
    @(negedge clk) applyStimulus(0, 1'b1, 1'b0, 2'd1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1 checkOutput("noGhost", 32'(busA.dec_out), 32'hD);
    end

    $display("[TB] auto-scan sequence");
    @(negedge clk) applyStimulus(0, 1'b1, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      checkOutput("scanSeq", 32'(busA.dec_out), 32'(scanSeq[i]));
      checkOutput("scanTick", 32'(busA.frame_tick), (i == 21) ? 1 : 0);
    end

    $display("[TB] enable drop during scan");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (busA.dec_out == 4'b1011) found = 1'b1;
    end
    checkOutput("reachIndex2", 32'(found), 1);
    @(negedge clk) applyStimulus(0, 1'b0, 1'b1, 2'd1, 1'b0);
    @(posedge clk); #1 checkOutput("enDropDark", 32'(busA.dec_out), 32'hF);
    checkOutput("enDropCurSelHeld", 32'(busA.cur_sel), 2);
    repeat (3) begin
      @(posedge clk); #1 checkOutput("idleHold", 32'(busA.dec_out), 32'hF);
    end
    @(negedge clk) applyStimulus(0, 1'b1, 1'b1, 2'd1, 1'b0);
    @(posedge clk); #1 checkOutput("reenableBlank", 32'(busA.dec_out), 32'hF);
    @(posedge clk); #1 checkOutput("restartIdx0", 32'(busA.dec_out), 32'hE);
    checkOutput("restartNoTick", 32'(busA.frame_tick), 0);

    $display("[TB] zero-blank instance");
    @(negedge clk) applyStimulus(1, 1'b1, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1 checkOutput("noBlankEnable", 32'(busB.dec_out), 32'hE);
    @(negedge clk) applyStimulus(1, 1'b1, 1'b0, 2'd3, 1'b1);
    @(posedge clk); #1 checkOutput("noBlankSingleEdge", 32'(busB.dec_out), 32'h7);
    checkOutput("noBlankCurSel", 32'(busB.cur_sel), 3);
    @(negedge clk) applyStimulus(1, 1'b1, 1'b1, 2'd3, 1'b0);
    repeat (18) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
